// File: rtl/param_readback.sv
// Parameter readback serialiser: snapshots a bank of parameter values on start and
// streams them as a byte frame (header, count, index/value groups, XOR checksum).
module param_readback #(
    parameter int          NUM_PARAMS = 4,
    parameter int          DATA_WIDTH = 32,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PARAMS*DATA_WIDTH-1:0] params_flat,
    input  logic                             start,
    output logic                             out_valid,
    output logic [7:0]                       out_data,
    output logic                             out_last,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done
);

    localparam int                NB        = DATA_WIDTH / 8;
    localparam int                SLOT_W    = $clog2(NUM_PARAMS + 1);
    localparam int                BC_W      = $clog2(NB + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_PARAMS - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(NB - 1);
    localparam logic [BC_W-1:0]   BC_ONE    = BC_W'(1);
    localparam logic [7:0]        CNT_BYTE  = 8'(NUM_PARAMS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_CNT  = 3'd2,
        S_IDX  = 3'd3,
        S_DATA = 3'd4,
        S_CSUM = 3'd5
    } state_t;

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic [7:0] idx_byte(input logic [SLOT_W-1:0] s);
        return 8'(s);
    endfunction

    state_t                            state_r;
    logic [NUM_PARAMS*DATA_WIDTH-1:0]  snap_r;
    logic [7:0]                        csum_r;
    logic [SLOT_W-1:0]                 slot_r;
    logic [BC_W-1:0]                   byte_r;
    logic [DATA_WIDTH-1:0]             word_r;
    logic [DATA_WIDTH-1:0]             word_shift_s;
    logic [DATA_WIDTH-1:0]             slot_word_s;
    logic                              accept_s;

    assign accept_s     = out_valid && out_ready;
    // Value bytes go out MSB first, so the working word shifts left one byte per accept.
    assign word_shift_s = word_r << 4'd8;

    // Select the snapshot word of the current slot.
    always_comb begin
        slot_word_s = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (slot_r == SLOT_W'(i)) begin
                slot_word_s = snap_r[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                slot_word_s = slot_word_s;
            end
        end
    end

    // Frame sequencer; every output is registered and the next byte is staged on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            snap_r    <= '0;
            csum_r    <= 8'h00;
            slot_r    <= '0;
            byte_r    <= '0;
            word_r    <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        snap_r    <= params_flat;
                        csum_r    <= 8'h00;
                        slot_r    <= '0;
                        byte_r    <= '0;
                        state_r   <= S_HDR;
                        out_valid <= 1'b1;
                        out_data  <= HDR_BYTE;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (accept_s) begin
                        csum_r   <= csum_next(csum_r, out_data);
                        state_r  <= S_CNT;
                        out_data <= CNT_BYTE;
                    end
                end
                S_CNT: begin
                    if (accept_s) begin
                        csum_r   <= csum_next(csum_r, out_data);
                        state_r  <= S_IDX;
                        out_data <= idx_byte(slot_r);
                    end
                end
                S_IDX: begin
                    if (accept_s) begin
                        csum_r   <= csum_next(csum_r, out_data);
                        state_r  <= S_DATA;
                        byte_r   <= '0;
                        word_r   <= slot_word_s;
                        out_data <= slot_word_s[DATA_WIDTH-1 -: 8];
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        csum_r <= csum_next(csum_r, out_data);
                        if (byte_r == LAST_BYTE) begin
                            if (slot_r == LAST_SLOT) begin
                                // The checksum must include the byte being accepted right now.
                                state_r  <= S_CSUM;
                                out_data <= csum_next(csum_r, out_data);
                                out_last <= 1'b1;
                            end else begin
                                slot_r   <= slot_r + SLOT_ONE;
                                state_r  <= S_IDX;
                                out_data <= idx_byte(slot_r + SLOT_ONE);
                            end
                        end else begin
                            byte_r   <= byte_r + BC_ONE;
                            word_r   <= word_shift_s;
                            out_data <= word_shift_s[DATA_WIDTH-1 -: 8];
                        end
                    end
                end
                S_CSUM: begin
                    if (accept_s) begin
                        state_r   <= S_IDLE;
                        out_valid <= 1'b0;
                        out_data  <= 8'h00;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    out_valid <= 1'b0;
                    out_data  <= 8'h00;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/param_readback.md
Name: param_readback

Overview:
- Runtime complement to elaboration-time parameter override: the override path writes configuration values into instances; this block reads them back out.
- Snapshots a bank of NUM_PARAMS parameter values on start and serialises them as a byte-framed stream over a valid/ready interface, ending with an XOR checksum.
- Sits beside configurable sub-instances, feeding a debug/UART byte sink so the values actually in effect can be confirmed on silicon.

Parameters:
- NUM_PARAMS, 4, number of parameter slots; legal range 1..255.
- DATA_WIDTH, 32, bits per parameter value; must be a multiple of 8 and at least 8.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- params_flat  input  NUM_PARAMS*DATA_WIDTH  slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- start  input  1  request one readback frame; sampled only in IDLE.
- out_valid  output  1  out_data is valid.
- out_data  output  8  stream byte.
- out_last  output  1  marks the checksum byte, the final byte of the frame.
- out_ready  input  1  sink accepts the byte when out_valid && out_ready.
- busy  output  1  high from frame start until the checksum byte is accepted.
- done  output  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, busy=0, done=0, state=IDLE, checksum=0, slot index=0, byte counter=0.
- Rst wins over every other input in the same cycle. Rst asserted mid-frame aborts the frame: next cycle all outputs are at reset values and no done pulse is produced.
- Frame format:
  - HDR_BYTE.
  - NUM_PARAMS[7:0].
  - For each slot i = 0..NUM_PARAMS-1: index byte i, then DATA_WIDTH/8 value bytes, MSB first.
  - Checksum byte = XOR of all preceding bytes in the frame.
  - Total length 3 + NUM_PARAMS*(1 + DATA_WIDTH/8) bytes.
- Snapshot: params_flat is registered in full in the cycle start is accepted. Later changes to params_flat do not affect the frame in flight.
- States and transitions:
  - IDLE -> HDR on start.
  - HDR -> CNT on accept.
  - CNT -> IDX on accept.
  - IDX -> DATA on accept.
  - DATA: after the last value byte is accepted, go to IDX if more slots remain, else to CSUM.
  - CSUM -> IDLE on accept.
- Latency: start high in IDLE at edge N gives out_valid=1 with out_data=HDR_BYTE after edge N; busy rises at the same edge.
- Handshake rules:
  - A byte transfers on a rising edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable and out_valid stays high. The source never retracts valid.
  - out_valid is continuously high from HDR through CSUM; there are no bubbles between bytes when out_ready is held high.
  - With out_ready held high, one byte transfers per cycle.
- Checksum: cleared on start, XOR-accumulated with each byte as it is accepted.
- Completion: on the edge accepting the CSUM byte, out_valid, out_last and busy go low and done=1 for exactly one cycle (state IDLE).
- start during that done cycle is accepted, giving a back-to-back frame.
- start while busy is ignored; it is neither queued nor does it restart the frame.
- Counter widths: slot index is $clog2(NUM_PARAMS+1) bits; byte counter is $clog2(DATA_WIDTH/8+1) bits. Neither counter may wrap inside a frame.
- NUM_PARAMS=1 and DATA_WIDTH=8 are legal corner configurations and must produce a correctly sized frame.

Test Plan:
- NUM_PARAMS=2, DATA_WIDTH=16, params {slot0=16'h0020, slot1=16'h0021}, out_ready=1, single start -> 9 bytes A5 02 00 00 20 01 00 21 A7 on consecutive cycles; out_last only on A7; done pulse one cycle after; busy high for exactly 9 cycles.
- Same configuration, out_ready toggled 1/0 every cycle -> identical byte sequence; out_data stable across every stalled cycle; 17 cycles from first valid to last accept.
- Default configuration (4x32), slot values 32'h00000020, 32'h00000021, 32'h0000000F, 32'h00000007 -> 23 bytes; value bytes MSB first (slot2 bytes 00 00 00 0F); checksum equals XOR of the preceding 22 bytes.
- Change params_flat and pulse start again mid-frame -> frame content unchanged, no restart, exactly one done pulse.
- Assert rst on the 4th accepted byte -> next cycle out_valid=0, busy=0, done=0. A following start yields a complete, correct frame whose checksum is unaffected by the aborted one.
- Hold start high continuously -> back-to-back frames, each new HDR appearing one cycle after the done pulse, with correct per-frame checksums.
